// File: rtl/ram_sequencer_if.sv
// ram_sequencer_if: bundles the command/status bus and the RAM-side bus of
// the ram_sequencer.
//   slave  : the sequencer. It takes the command and ram_data_out, and it
//            drives the RAM strobes/address/data and the status outputs.
//   master : the control logic and the RAM that connect to the sequencer.
// Command:  start, mode (00 fill, 01 verify, 10 clear, 11 reserved),
//           base_addr, last_addr (inclusive), seed.
// RAM:      ram_address, ram_data_in, ram_write, ram_chip_select, ram_data_out.
// Status:   busy, done, cmd_err, err_count, first_err_valid, first_err_addr.
interface ram_sequencer_if #(
    parameter int AW = 10,
    parameter int DW = 10
);
    logic          start;
    logic [1:0]    mode;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] seed;

    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in;
    logic          ram_write;
    logic          ram_chip_select;
    logic [DW-1:0] ram_data_out;

    logic          busy;
    logic          done;
    logic          cmd_err;
    logic [AW:0]   err_count;
    logic          first_err_valid;
    logic [AW-1:0] first_err_addr;

    modport slave (
        input  start, mode, base_addr, last_addr, seed, ram_data_out,
        output ram_address, ram_data_in, ram_write, ram_chip_select,
               busy, done, cmd_err, err_count, first_err_valid, first_err_addr
    );

    modport master (
        output start, mode, base_addr, last_addr, seed, ram_data_out,
        input  ram_address, ram_data_in, ram_write, ram_chip_select,
               busy, done, cmd_err, err_count, first_err_valid, first_err_addr
    );
endinterface

// File: rtl/ram_sequencer.sv
// ram_sequencer: hardware fill / clear / verify engine for a single-port RAM.
// Each accepted command walks base..last (inclusive, wrapping modulo 2^AW) at
// one access per cycle. A fill writes pat(a) = a ^ seed and a clear writes 0.
// A verify reads every address and compares the returned data, which arrives
// RD_LAT cycles after the read, against pat(a).
// Ports:
//   i_clk_reset : clock, rising edge.
//   i_reset     : asynchronous active-low reset.
//   io_bus      : command, RAM and status signals (ram_sequencer_if.slave).
module ram_sequencer #(
    parameter int AW     = 10,
    parameter int DW     = 10,
    parameter int RD_LAT = 1
) (
    input  logic           i_clk_reset,
    input  logic           i_reset,
    ram_sequencer_if.slave io_bus
);
    localparam logic [1:0] MODE_FILL   = 2'b00;
    localparam logic [1:0] MODE_VERIFY = 2'b01;
    localparam logic [1:0] MODE_RSVD   = 2'b11;
    localparam int         CW          = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                   r_state, w_next;
    logic [1:0]               r_mode;
    logic [AW-1:0]            r_addr, r_last;
    logic [DW-1:0]            r_seed;
    logic [CW-1:0]            r_drain_cnt;
    logic [RD_LAT-1:0]        r_pipe_vld;
    logic [RD_LAT-1:0][AW-1:0] r_pipe_addr;
    logic [AW:0]              r_err_count;
    logic                     r_first_vld;
    logic [AW-1:0]            r_first_addr;
    logic                     r_cmd_err;

    logic w_accept, w_last_issue, w_rd_issue, w_cmp_fail;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a, input logic [DW-1:0] s);
        return DW'(a) ^ s;
    endfunction

    assign w_accept     = (r_state == S_IDLE) && io_bus.start && (io_bus.mode != MODE_RSVD);
    assign w_last_issue = (r_state == S_RUN) && (r_addr == r_last);
    assign w_rd_issue   = (r_state == S_RUN) && (r_mode == MODE_VERIFY);
    // The oldest pipe entry lines up with the data the RAM is returning now.
    assign w_cmp_fail   = r_pipe_vld[RD_LAT-1] &&
                          (io_bus.ram_data_out != pat(r_pipe_addr[RD_LAT-1], r_seed));

    // State register
    always_ff @(posedge i_clk_reset or negedge i_reset) begin
        if (!i_reset) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_RUN;
            S_RUN:   if (w_last_issue) w_next = (r_mode == MODE_VERIFY) ? S_DRAIN : S_DONE;
            S_DRAIN: if (r_drain_cnt == '0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic. Every RAM output is gated by state, so reset forces the
    // strobes, address and data to 0 without waiting for a clock.
    always_comb begin
        io_bus.ram_chip_select = 1'b0;
        io_bus.ram_write       = 1'b0;
        io_bus.ram_address     = '0;
        io_bus.ram_data_in     = '0;
        io_bus.busy            = 1'b0;
        io_bus.done            = 1'b0;
        case (r_state)
            S_RUN: begin
                io_bus.ram_chip_select = 1'b1;
                io_bus.ram_address     = r_addr;
                io_bus.ram_write       = (r_mode != MODE_VERIFY);
                io_bus.busy            = 1'b1;
                if (r_mode == MODE_FILL) io_bus.ram_data_in = pat(r_addr, r_seed);
            end
            S_DRAIN: io_bus.busy = 1'b1;
            S_DONE:  io_bus.done = 1'b1;
            default: ;
        endcase
    end

    assign io_bus.cmd_err         = r_cmd_err;
    assign io_bus.err_count       = r_err_count;
    assign io_bus.first_err_valid = r_first_vld;
    assign io_bus.first_err_addr  = r_first_addr;

    // Command capture, address walk, read pipe and result tracking
    always_ff @(posedge i_clk_reset or negedge i_reset) begin
        if (!i_reset) begin
            r_mode       <= '0;
            r_addr       <= '0;
            r_last       <= '0;
            r_seed       <= '0;
            r_drain_cnt  <= '0;
            r_pipe_vld   <= '0;
            r_pipe_addr  <= '0;
            r_err_count  <= '0;
            r_first_vld  <= 1'b0;
            r_first_addr <= '0;
            r_cmd_err    <= 1'b0;
        end else begin
            r_cmd_err <= (r_state == S_IDLE) && io_bus.start && (io_bus.mode == MODE_RSVD);

            if (w_accept) begin
                r_mode <= io_bus.mode;
                r_addr <= io_bus.base_addr;
                r_last <= io_bus.last_addr;
                r_seed <= io_bus.seed;
            end else if (r_state == S_RUN) begin
                r_addr <= r_addr + AW'(1);   // wraps modulo 2^AW
            end

            // DRAIN runs from RD_LAT-1 down to 0, so it lasts exactly RD_LAT cycles.
            if (w_last_issue)
                r_drain_cnt <= CW'(RD_LAT - 1);
            else if (r_state == S_DRAIN)
                r_drain_cnt <= r_drain_cnt - CW'(1);

            r_pipe_vld[0]  <= w_rd_issue;
            r_pipe_addr[0] <= r_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_addr[i] <= r_pipe_addr[i-1];
            end

            if (w_accept) begin
                r_err_count  <= '0;
                r_first_vld  <= 1'b0;
                r_first_addr <= '0;
            end else if (w_cmp_fail) begin
                r_err_count <= r_err_count + (AW+1)'(1);
                if (!r_first_vld) begin
                    r_first_vld  <= 1'b1;
                    r_first_addr <= r_pipe_addr[RD_LAT-1];
                end
            end
        end
    end
endmodule

// File: tb/tb_ram_sequencer.sv
module tb_ram_sequencer;
    localparam int AW = 10;
    localparam int DW = 10;
    localparam int NW = 1 << AW;
    localparam logic [1:0] M_FILL = 2'b00, M_VFY = 2'b01, M_CLR = 2'b10, M_RSV = 2'b11;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_sequencer_if #(.AW(AW), .DW(DW)) bus1 ();
    ram_sequencer_if #(.AW(AW), .DW(DW)) bus3 ();

    ram_sequencer #(.AW(AW), .DW(DW), .RD_LAT(1)) dut1 (
        .i_clk_reset(clk), .i_reset(rst_n), .io_bus(bus1));
    ram_sequencer #(.AW(AW), .DW(DW), .RD_LAT(3)) dut3 (
        .i_clk_reset(clk), .i_reset(rst_n), .io_bus(bus3));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // RAM model: dut1 writes it. dut1 reads it with latency 1 and dut3 reads
    // it with latency 3. cmask XORs injected faults into the returned data.
    logic [DW-1:0]    mem   [NW];
    logic [DW-1:0]    cmask [NW];
    logic [DW-1:0]    rp3   [3];
    logic [AW+DW-1:0] wlog  [$];

    always @(posedge clk) begin
        if (bus1.ram_chip_select && bus1.ram_write) begin
            mem[bus1.ram_address] <= bus1.ram_data_in;
            wlog.push_back({bus1.ram_address, bus1.ram_data_in});
        end
        bus1.ram_data_out <= mem[bus1.ram_address] ^ cmask[bus1.ram_address];
        rp3[0] <= mem[bus3.ram_address] ^ cmask[bus3.ram_address];
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end
    assign bus3.ram_data_out = rp3[2];

    // The reference contents of the RAM, derived from the commands alone.
    logic [DW-1:0] ref_mem [NW];

    logic [1:0]    done_v, busy_v, cs_v, we_v, cerr_v, fev_v;
    logic [AW:0]   ec_v  [2];
    logic [AW-1:0] fea_v [2];
    logic [AW-1:0] adr_v [2];
    logic [DW-1:0] din_v [2];
    assign done_v   = {bus3.done, bus1.done};
    assign busy_v   = {bus3.busy, bus1.busy};
    assign cs_v     = {bus3.ram_chip_select, bus1.ram_chip_select};
    assign we_v     = {bus3.ram_write, bus1.ram_write};
    assign cerr_v   = {bus3.cmd_err, bus1.cmd_err};
    assign fev_v    = {bus3.first_err_valid, bus1.first_err_valid};
    assign ec_v[0]  = bus1.err_count;       assign ec_v[1]  = bus3.err_count;
    assign fea_v[0] = bus1.first_err_addr;  assign fea_v[1] = bus3.first_err_addr;
    assign adr_v[0] = bus1.ram_address;     assign adr_v[1] = bus3.ram_address;
    assign din_v[0] = bus1.ram_data_in;     assign din_v[1] = bus3.ram_data_in;

    function automatic logic [DW-1:0] pat(input int a, input int seed);
        return DW'((a ^ seed) & (NW - 1));
    endfunction

    task automatic drive(input int w, input logic s, input logic [1:0] m,
                         input int b, input int l, input int sd);
        if (w == 0) begin
            bus1.start = s; bus1.mode = m; bus1.base_addr = AW'(b);
            bus1.last_addr = AW'(l); bus1.seed = DW'(sd);
        end else begin
            bus3.start = s; bus3.mode = m; bus3.base_addr = AW'(b);
            bus3.last_addr = AW'(l); bus3.seed = DW'(sd);
        end
    endtask

    task automatic chk_quiet(input int w, input string tag);
        chk(tag, {cs_v[w], we_v[w], busy_v[w], done_v[w], adr_v[w], din_v[w]}, 0);
    endtask

    // Runs one command to completion, then checks its latency, its write
    // stream or verify results, and the done pulse. poke_at >= 1 gives a
    // start pulse in that cycle of the run.
    task automatic run(input int w, input logic [1:0] m, input int base, input int last,
                       input int seed, input int poke_at);
        int n, cyc, w0, exp_lat, nerr, first, nbadw, a;
        logic [DW-1:0] d;
        n       = ((last - base) & (NW - 1)) + 1;
        exp_lat = (m == M_VFY) ? n + ((w != 0) ? 3 : 1) + 1 : n + 1;
        w0      = wlog.size();
        @(negedge clk);
        drive(w, 1'b1, m, base, last, seed);
        @(posedge clk); #1;
        // Scramble the command inputs; the captured values must be the ones used.
        drive(w, 1'b0, 2'($urandom), int'($urandom), int'($urandom), int'($urandom));
        chk("busy_first", busy_v[w], 1);
        cyc = 1;
        while (!done_v[w] && cyc < 4000) begin
            drive(w, cyc == poke_at, M_VFY, 0, NW - 1, 0);
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", cyc, exp_lat);
        chk("busy_at_done", busy_v[w], 0);
        if (m == M_VFY) begin
            nerr = 0; first = -1;
            for (int i = 0; i < n; i++) begin
                a = (base + i) & (NW - 1);
                if ((ref_mem[a] ^ cmask[a]) != pat(a, seed)) begin
                    nerr++;
                    if (first < 0) first = a;
                end
            end
            chk("err_count", ec_v[w], nerr);
            chk("first_valid", fev_v[w], first >= 0);
            if (first >= 0) chk("first_addr", fea_v[w], first);
            if (w == 0) chk("verify_no_write", wlog.size() - w0, 0);
        end else begin
            nbadw = 0;
            chk("write_count", wlog.size() - w0, n);
            for (int i = 0; i < n; i++) begin
                a = (base + i) & (NW - 1);
                d = (m == M_FILL) ? pat(a, seed) : '0;
                ref_mem[a] = d;
                if (w0 + i >= wlog.size() || wlog[w0 + i] != {AW'(a), d}) nbadw++;
            end
            chk("write_seq", nbadw, 0);
        end
        @(posedge clk); #1;
        chk("done_pulse", done_v[w], 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, seen, base, len, last, seed, ca;
        logic [1:0] m;
        for (int i = 0; i < NW; i++) cmask[i] = '0;
        drive(0, 1'b0, M_FILL, 0, 0, 0);
        drive(1, 1'b0, M_FILL, 0, 0, 0);
        #12;
        for (int w = 0; w < 2; w++) begin
            chk_quiet(w, "reset_outputs");
            chk("reset_results", {cerr_v[w], fev_v[w], fea_v[w], ec_v[w]}, 0);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Identity fill, then a clean verify on both latencies
        run(0, M_FILL, 0, NW - 1, 0, 0);
        run(0, M_VFY, 0, NW - 1, 0, 0);
        run(1, M_VFY, 0, NW - 1, 0, 0);

        // Seeded fill with two corrupted locations
        run(0, M_FILL, 0, NW - 1, 'h155, 0);
        cmask[37] = 10'h001; cmask[900] = 10'h200;
        run(0, M_VFY, 0, NW - 1, 'h155, 0);
        run(1, M_VFY, 0, NW - 1, 'h155, 0);
        cmask[37] = '0; cmask[900] = '0;

        // Wrapping range and single word
        run(0, M_FILL, 1020, 3, 0, 0);
        run(0, M_FILL, 5, 5, 'h2A, 0);

        // Clear, then verify against seed 0: every nonzero address mismatches
        run(0, M_CLR, 0, NW - 1, 0, 0);
        run(0, M_VFY, 0, NW - 1, 0, 0);
        run(1, M_VFY, 0, NW - 1, 0, 0);

        // Reserved mode
        @(negedge clk);
        drive(0, 1'b1, M_RSV, 0, 10, 0);
        @(posedge clk); #1;
        chk("cmd_err_pulse", cerr_v[0], 1);
        chk("cmd_err_busy", busy_v[0], 0);
        chk("cmd_err_strobes", {cs_v[0], we_v[0]}, 0);
        drive(0, 1'b0, M_FILL, 0, 0, 0);
        @(posedge clk); #1;
        chk("cmd_err_once", cerr_v[0], 0);
        chk_quiet(0, "cmd_err_idle");

        // Reset in the middle of a fill; dut3 still holds its verify errors.
        w0 = wlog.size();
        @(negedge clk);
        drive(0, 1'b1, M_FILL, 0, NW - 1, 'h0F0);
        @(posedge clk); #1;
        drive(0, 1'b0, M_FILL, 0, 0, 0);
        repeat (299) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_quiet(0, "rst_mid_strobes");
        chk("rst_mid_writes", wlog.size() - w0, 299);
        for (int i = 0; i < 299; i++) ref_mem[i] = pat(i, 'h0F0);
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            seen = seen | done_v[0];
        end
        chk("rst_no_done", seen, 0);
        chk("rst_no_more_writes", wlog.size() - w0, 299);
        chk("rst_clears_results", {fev_v[1], ec_v[1]}, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // A full fill after reset with a start poke in the middle of the run
        run(0, M_FILL, 0, NW - 1, 'h3C3, 100);
        run(0, M_VFY, 0, NW - 1, 'h3C3, 0);

        // Random short commands
        for (int it = 0; it < 14; it++) begin
            m    = 2'($urandom_range(0, 2));
            base = int'($urandom_range(0, NW - 1));
            len  = int'($urandom_range(1, 40));
            last = (base + len - 1) & (NW - 1);
            seed = int'($urandom_range(0, NW - 1));
            if (m == M_VFY) begin
                ca = (base + int'($urandom_range(0, len - 1))) & (NW - 1);
                if ($urandom_range(0, 1) == 1) cmask[ca] = DW'($urandom_range(1, NW - 1));
                run(0, m, base, last, seed, 0);
                run(1, m, base, last, seed, 0);
                cmask[ca] = '0;
            end else begin
                run(0, m, base, last, seed, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
